// File: rtl/conv_window_gen.sv
`default_nettype none
// ============================================================================
//  Module   : conv_window_gen
//  Purpose  : Streaming NxN window generator. Accepts a raster-order pixel
//             stream and emits every fully populated NxN window in the packed
//             layout consumed by the dot-product stage
//             (element e = r*N + c at bits [e*BitSize +: BitSize];
//             r = 0 is the oldest row and c = N-1 is the newest pixel).
//  Ports    : clk        - rising-edge clock
//             reset      - synchronous active-high reset
//             in_valid   - in_data carries a pixel
//             in_ready   - pixel can be accepted this cycle
//             in_data    - pixel, row-major raster order
//             out_valid  - out_window carries a complete window
//             out_ready  - downstream takes the window this cycle
//             out_window - packed NxN window
//             out_last   - final window of the frame (qualified by out_valid)
//  Revision : 1.0 - initial release
// ============================================================================
module conv_window_gen #(
  parameter int N           = 3,
  parameter int BitSize     = 8,
  parameter int ImageWidth  = 28,
  parameter int ImageHeight = 28
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [BitSize-1:0]        in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [BitSize*N*N-1:0]    out_window,
  output logic                      out_last
);

  localparam int COL_W = (ImageWidth  > 1) ? $clog2(ImageWidth)  : 1;
  localparam int ROW_W = (ImageHeight > 1) ? $clog2(ImageHeight) : 1;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(ImageWidth - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ImageHeight - 1);
  localparam logic [COL_W-1:0] COL_MIN  = COL_W'(N - 1);
  localparam logic [ROW_W-1:0] ROW_MIN  = ROW_W'(N - 1);

  logic [COL_W-1:0]   col_q, col_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic               out_valid_q;
  logic               out_last_q;

  // lb_q[0] holds the oldest buffered row, lb_q[N-2] the row just above the
  // one currently streaming in.
  logic [BitSize-1:0] lb_q  [N-1][ImageWidth];
  logic [BitSize-1:0] win_q [N][N];

  logic               accept;
  logic               qualify;
  logic               frame_end;

  // Backpressure only ever comes from a held, untaken window.
  assign in_ready  = !out_valid_q || out_ready;
  assign accept    = in_valid && in_ready;

  // Gating on the current pixel position keeps windows that would straddle a
  // row or frame boundary from ever being flagged valid.
  assign qualify   = (row_q >= ROW_MIN) && (col_q >= COL_MIN);
  assign frame_end = (row_q == ROW_LAST) && (col_q == COL_LAST);

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (col_q == COL_LAST) begin
      col_d = '0;
      row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
    end else begin
      col_d = col_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      row_q       <= '0;
      col_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          win_q[r][c] <= '0;
        end
      end
      for (int k = 0; k < N - 1; k++) begin
        for (int x = 0; x < ImageWidth; x++) begin
          lb_q[k][x] <= '0;
        end
      end
    end else if (accept) begin
      row_q       <= row_d;
      col_q       <= col_d;
      out_valid_q <= qualify;
      out_last_q  <= qualify && frame_end;

      // Slide the window one column left.
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N - 1; c++) begin
          win_q[r][c] <= win_q[r][c+1];
        end
      end
      // New right-hand column: buffered rows above, then the incoming pixel.
      for (int r = 0; r < N - 1; r++) begin
        win_q[r][N-1] <= lb_q[r][col_q];
      end
      win_q[N-1][N-1] <= in_data;

      // Age this column of the line buffers by one row.
      for (int k = 0; k < N - 2; k++) begin
        lb_q[k][col_q] <= lb_q[k+1][col_q];
      end
      lb_q[N-2][col_q] <= in_data;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end
  end

  generate
    for (genvar gr = 0; gr < N; gr++) begin : g_row
      for (genvar gc = 0; gc < N; gc++) begin : g_col
        assign out_window[(gr*N + gc)*BitSize +: BitSize] = win_q[gr][gc];
      end
    end
  endgenerate

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;

endmodule
`default_nettype wire

// File: tb/tb_conv_window_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_conv_window_gen
//  Purpose  : Self-checking bench for conv_window_gen (N=3, 8-bit, 4x4 image)
//             against a frame-array reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_conv_window_gen;

  localparam int N  = 3;
  localparam int B  = 8;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int WB = B * N * N;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [B-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [WB-1:0] out_window;
  logic          out_last;

  conv_window_gen #(
    .N           (N),
    .BitSize     (B),
    .ImageWidth  (W),
    .ImageHeight (H)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_window (out_window),
    .out_last   (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: pixels of the current frame plus pending windows.
  int            mdl_n;
  logic [B-1:0]  img [W*H];
  logic [WB-1:0] q_win  [$];
  bit            q_last [$];

  // Windows actually taken from the DUT in the current scenario.
  logic [WB-1:0] log_win  [$];
  bit            log_last [$];
  logic [WB-1:0] ref_win  [4];

  int src_idx;

  task automatic check(input string tag, input logic [WB-1:0] got, input logic [WB-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [B-1:0] pix(input int idx);
    int f, p;
    f = idx / (W*H);
    p = idx % (W*H);
    return B'(((f != 0) ? 100 : 0) + p);
  endfunction

  function automatic logic [WB-1:0] win_at(input int base, input int r0, input int c0);
    logic [WB-1:0] w;
    w = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        w[(i*N+j)*B +: B] = B'(base + (r0+i)*W + c0 + j);
    return w;
  endfunction

  task automatic model_accept(input logic [B-1:0] d);
    int r, c;
    logic [WB-1:0] w;
    r = mdl_n / W;
    c = mdl_n % W;
    img[mdl_n] = d;
    if (r >= N-1 && c >= N-1) begin
      w = '0;
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          w[(i*N+j)*B +: B] = img[(r-N+1+i)*W + (c-N+1+j)];
      q_win.push_back(w);
      q_last.push_back(mdl_n == W*H-1);
    end
    mdl_n = (mdl_n + 1) % (W*H);
  endtask

  task automatic cycle(input bit v, input bit ordy);
    bit exp_v, exp_r;
    in_valid  = v;
    out_ready = ordy;
    in_data   = v ? pix(src_idx) : B'($urandom);
    @(negedge clk);
    exp_v = (q_win.size() != 0);
    exp_r = !exp_v || ordy;
    check("in_ready", WB'(in_ready), WB'(exp_r));
    check("out_valid", WB'(out_valid), WB'(exp_v));
    if (exp_v) begin
      check("window", out_window, q_win[0]);
      check("last", WB'(out_last), WB'(q_last[0]));
    end
    if (exp_v && ordy) begin
      log_win.push_back(out_window);
      log_last.push_back(out_last);
      void'(q_win.pop_front());
      void'(q_last.pop_front());
    end
    if (v && exp_r) begin
      model_accept(in_data);
      src_idx++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    q_win.delete();
    q_last.delete();
    log_win.delete();
    log_last.delete();
    mdl_n   = 0;
    src_idx = 0;
    @(negedge clk);
    check("rst_out_valid", WB'(out_valid), WB'(0));
    check("rst_out_window", out_window, WB'(0));
    check("rst_out_last", WB'(out_last), WB'(0));
    check("rst_in_ready", WB'(in_ready), WB'(1));
    @(posedge clk);
    #1;
  endtask

  // mode 0: continuous; 1: sparse valid + random ready;
  // 2: 5-cycle stall on the first window; 3: out_ready held low
  task automatic feed(input int npix, input int mode);
    int  budget;
    int  stall;
    bit  v, r;
    budget = 0;
    stall  = 0;
    while (src_idx < npix && budget < 400) begin
      v = 1'b1;
      r = 1'b1;
      case (mode)
        1: begin
          v = budget[0];
          r = 1'($urandom_range(0, 1));
        end
        2: begin
          if (log_win.size() == 0 && q_win.size() != 0 && stall < 5) begin
            r = 1'b0;
            stall++;
          end
        end
        3: r = 1'b0;
        default: ;
      endcase
      cycle(v, r);
      budget++;
    end
    check("feed_budget", WB'(src_idx), WB'(npix));
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while (q_win.size() != 0 && budget < 50) begin
      cycle(1'b0, 1'($urandom_range(0, 1)));
      budget++;
    end
    cycle(1'b0, 1'b1);
    check("drain_budget", WB'(q_win.size()), WB'(0));
  endtask

  task automatic compare_to_ref(input string tag);
    check({tag, "_count"}, WB'(log_win.size()), WB'(4));
    for (int k = 0; k < 4; k++) begin
      check({tag, "_win"}, log_win[k], ref_win[k]);
      check({tag, "_lastpos"}, WB'(log_last[k]), WB'(k == 3));
    end
  endtask

  initial begin
    bit mixed, hi0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in_data   = '0;
    mdl_n     = 0;
    src_idx   = 0;
    repeat (3) @(posedge clk);
    #1;

    // Single frame, continuous.
    do_reset();
    feed(16, 0);
    drain();
    check("s1_count", WB'(log_win.size()), WB'(4));
    check("s1_first", log_win[0], win_at(0, 0, 0));
    check("s1_last", log_win[3], win_at(0, 1, 1));
    for (int k = 0; k < 4; k++) begin
      check("s1_lastpos", WB'(log_last[k]), WB'(k == 3));
      ref_win[k] = log_win[k];
    end

    // Backpressure on the first window.
    do_reset();
    feed(16, 2);
    drain();
    compare_to_ref("s2");

    // Sparse input with random downstream readiness.
    do_reset();
    feed(16, 1);
    drain();
    compare_to_ref("s3");

    // Two frames back to back.
    do_reset();
    feed(32, 0);
    drain();
    check("s4_count", WB'(log_win.size()), WB'(8));
    check("s4_win5", log_win[4], win_at(100, 0, 0));
    for (int k = 0; k < 8; k++) begin
      check("s4_lastpos", WB'(log_last[k]), WB'(k == 3 || k == 7));
      mixed = 1'b0;
      hi0   = (log_win[k][7:0] >= 8'd100);
      for (int e = 1; e < N*N; e++)
        if ((log_win[k][e*B +: B] >= 8'd100) != hi0) mixed = 1'b1;
      check("s4_mixed", WB'(mixed), WB'(0));
    end

    // Reset after 7 pixels, then a fresh frame.
    do_reset();
    feed(7, 0);
    do_reset();
    feed(16, 0);
    drain();
    compare_to_ref("s5");

    // Reset while a window is held and stalled.
    do_reset();
    feed(11, 3);
    repeat (3) cycle(1'b1, 1'b0);
    check("s6_held", WB'(out_valid), WB'(1));
    out_ready = 1'b0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    q_win.delete();
    q_last.delete();
    mdl_n   = 0;
    src_idx = 0;
    @(negedge clk);
    check("s6_out_valid", WB'(out_valid), WB'(0));
    check("s6_in_ready", WB'(in_ready), WB'(1));
    @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
